uart_tx: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx.sv | 137 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared UART state encodings and line levels          rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b1;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_if : byte request / serial line bundle for uart_tx      rev 1.0
// ----------------------------------------------------------------------------
interface uart_tx_if;
   import uart_pkg::*;

   logic                 tx_start;
   logic [DATA_BITS-1:0] tdata;
   logic                 txd;
   logic                 tx_busy;
   logic                 tx_ack;

   modport master (output tx_start, tdata, input txd, tx_busy, tx_ack);
   modport slave  (input tx_start, tdata, output txd, tx_busy, tx_ack);

endinterface
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// uart_baud_tick : flags the last clock of every bit period       rev 1.0
// ----------------------------------------------------------------------------
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick
);

   localparam int             C_CW   = cnt_width(CLKS_PER_BIT);
   localparam logic [C_CW-1:0] C_LAST = C_CW'(CLKS_PER_BIT - 1);

   logic [C_CW-1:0] r_cnt;

   assign bit_tick = (r_cnt == C_LAST);

   always_ff @(posedge clk) begin
      if (rst || clear || bit_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx : start + 8 data (LSB first) + STOP_BITS stop serializer rev 1.0
// ----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   localparam logic [2:0] C_LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic [2:0] C_LAST_STOP = 3'(STOP_BITS - 1);

   logic [1:0]           r_state, w_state_nxt;
   logic                 r_txd, w_txd_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_ack, w_ack_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic [2:0]           r_bit, w_bit_nxt;
   logic                 w_tick;
   logic                 w_clear;

   // Holding the baud counter clear while idle aligns every bit to the accept edge.
   assign w_clear = (r_state == IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_clear),
      .bit_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.tx_start) w_state_nxt = START;
         START:   if (w_tick) w_state_nxt = DATA;
         DATA:    if (w_tick && (r_bit == C_LAST_BIT)) w_state_nxt = STOP;
         STOP:    if (w_tick && (r_bit == C_LAST_STOP)) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_txd_nxt   = r_txd;
      w_busy_nxt  = r_busy;
      w_ack_nxt   = 1'b0;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      case (r_state)
         IDLE: begin
            w_txd_nxt  = IDLE_LEVEL;
            w_busy_nxt = 1'b0;
            if (bus.tx_start) begin
               w_shift_nxt = bus.tdata;
               w_busy_nxt  = 1'b1;
               w_txd_nxt   = START_LEVEL;
               w_bit_nxt   = 3'd0;
            end
         end
         START: begin
            if (w_tick) begin
               w_txd_nxt = r_shift[0];
               w_bit_nxt = 3'd0;
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit == C_LAST_BIT) begin
                  w_txd_nxt = STOP_LEVEL;
                  w_bit_nxt = 3'd0;
               end else begin
                  w_shift_nxt = r_shift >> 1;
                  w_txd_nxt   = r_shift[1];
                  w_bit_nxt   = r_bit + 3'd1;
               end
            end
         end
         STOP: begin
            // The bit counter is reused to count stop bits.
            if (w_tick) begin
               if (r_bit == C_LAST_STOP) begin
                  w_txd_nxt  = IDLE_LEVEL;
                  w_busy_nxt = 1'b0;
                  w_ack_nxt  = 1'b1;
                  w_bit_nxt  = 3'd0;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         default: begin
            w_txd_nxt  = IDLE_LEVEL;
            w_busy_nxt = 1'b0;
            w_bit_nxt  = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_txd   <= IDLE_LEVEL;
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
         r_shift <= '0;
         r_bit   <= 3'd0;
      end else begin
         r_txd   <= w_txd_nxt;
         r_busy  <= w_busy_nxt;
         r_ack   <= w_ack_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
      end
   end

   assign bus.txd     = r_txd;
   assign bus.tx_busy = r_busy;
   assign bus.tx_ack  = r_ack;

endmodule
`default_nettype wire
